mbs_bus_responder: RTL and testbench

//  Shared-bus responder for the dual-CPU MBSsoc: arbitrates word accesses from cpu0/cpu1,

---
 rtl/mbs_bus_pkg.sv | 32 +++
 rtl/mbs_sram_1rw.sv | 23 ++
 rtl/mbs_bus_responder.sv | 145 ++++++++++++++
 tb/tb_mbs_bus_responder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mbs_bus_pkg.sv
// Shared types and constants for the MBSsoc bus responder.
// Covers the FSM state encoding, the ctrl debug-bus bit layout and the default error word.
package mbs_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } bus_state_t;

    localparam int CTRL_BUSY_BIT  = 0;
    localparam int CTRL_ERR_BIT   = 3;
    localparam int CTRL_WE_BIT    = 4;
    localparam int CTRL_OWNER_BIT = 5;
    localparam int CTRL_STATE_LSB = 6;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic logic [31:0] pack_ctrl(input bus_state_t st, input logic owner,
                                              input logic we_l, input logic err,
                                              input logic busy);
        logic [31:0] w;
        w = '0;
        w[CTRL_STATE_LSB +: 2] = st;
        w[CTRL_OWNER_BIT]      = owner;
        w[CTRL_WE_BIT]         = we_l;
        w[CTRL_ERR_BIT]        = err;
        w[CTRL_BUSY_BIT]       = busy;
        return w;
    endfunction

endpackage

// File: rtl/mbs_sram_1rw.sv
// Single-port synchronous RAM, DEPTH x 32, registered read (old data on a same-cycle write).
// Contents are never reset so the array maps onto block RAM.
module mbs_sram_1rw #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   q
);

    logic [31:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
        q <= mem_reg[addr];
    end

endmodule

// File: rtl/mbs_bus_responder.sv
// Dual-CPU shared-bus responder: round-robin arbitration, wait-stated RAM access,
// one-cycle ack pulse, per-CPU pause and debug-bus snapshots of the current/last access.
module mbs_bus_responder
    import mbs_bus_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata,
    output logic [1:0]  ack,
    output logic        err,
    output logic [1:0]  cpu_pause,
    output logic [31:0] data_bus_out,
    output logic [31:0] addr_bus_out,
    output logic [31:0] ctrl_bus_out
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) << 2;
    localparam logic [3:0]  WS_INIT    = 4'(WAIT_STATES);

    bus_state_t  state_reg, state_next;
    logic        owner_reg, last_grant_reg, we_l_reg, err_reg;
    logic [31:0] addr_l_reg, wdata_l_reg, rdata_reg, data_bus_reg;
    logic [3:0]  cnt_reg;
    logic [1:0]  ack_reg;

    logic          grant_sel;
    logic [31:0]   sel_addr;
    logic          op_fire, in_range, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_q;

    // Single requester wins; on contention the CPU that did not win last time goes first.
    always_comb begin
        grant_sel = 1'b0;
        if (req == 2'b10) begin
            grant_sel = 1'b1;
        end else if (req == 2'b11) begin
            grant_sel = ~last_grant_reg;
        end
    end

    assign sel_addr = grant_sel ? addr1 : addr0;
    assign op_fire  = (state_reg == ACCESS) && (cnt_reg == 4'd0);
    assign in_range = {1'b0, addr_l_reg} < ADDR_LIMIT;
    assign ram_we   = op_fire && we_l_reg && in_range;
    // Present the incoming address during IDLE so read data is ready even with zero wait states.
    assign ram_addr = (state_reg == IDLE) ? sel_addr[AW+1:2] : addr_l_reg[AW+1:2];

    mbs_sram_1rw #(.DEPTH(DEPTH), .AW(AW)) u_sram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_l_reg),
        .q     (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (|req) state_next = ACCESS;
            ACCESS:  if (op_fire) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            we_l_reg       <= 1'b0;
            err_reg        <= 1'b0;
            addr_l_reg     <= '0;
            wdata_l_reg    <= '0;
            rdata_reg      <= '0;
            data_bus_reg   <= '0;
            cnt_reg        <= '0;
            ack_reg        <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        owner_reg   <= grant_sel;
                        we_l_reg    <= we[grant_sel];
                        addr_l_reg  <= sel_addr;
                        wdata_l_reg <= grant_sel ? wdata1 : wdata0;
                        cnt_reg     <= WS_INIT;
                        if (we[grant_sel]) begin
                            data_bus_reg <= grant_sel ? wdata1 : wdata0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        ack_reg <= owner_reg ? 2'b10 : 2'b01;
                        err_reg <= ~in_range;
                        if (!we_l_reg) begin
                            rdata_reg    <= in_range ? ram_q : ERR_DATA;
                            data_bus_reg <= in_range ? ram_q : ERR_DATA;
                        end
                    end
                end
                DONE: begin
                    ack_reg        <= '0;
                    err_reg        <= 1'b0;
                    last_grant_reg <= owner_reg;
                end
                default: begin
                    ack_reg <= '0;
                    err_reg <= 1'b0;
                end
            endcase
        end
    end

    assign rdata        = rdata_reg;
    assign ack          = ack_reg;
    assign err          = err_reg;
    assign cpu_pause    = req & ~ack_reg;
    assign data_bus_out = data_bus_reg;
    assign addr_bus_out = addr_l_reg;
    assign ctrl_bus_out = pack_ctrl(state_reg, owner_reg, we_l_reg, err_reg, state_reg != IDLE);

endmodule

// File: tb/tb_mbs_bus_responder.sv
// Self-checking bench for mbs_bus_responder: directed scenarios plus randomized
// single/dual-CPU traffic against a transaction-level memory and arbitration model.
module tb_mbs_bus_responder;

    localparam int          DEPTH    = 1024;
    localparam int          WS       = 1;
    localparam int          LAT      = WS + 2;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  req = '0;
    logic [1:0]  we = '0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [31:0] rdata, data_bus_out, addr_bus_out, ctrl_bus_out;
    logic [1:0]  ack, cpu_pause;
    logic        err;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem_model [int unsigned];
    logic [31:0] rdata_model = '0;
    logic        lg_model = 1'b1;

    logic        op_we    [2];
    logic [31:0] op_addr  [2];
    logic [31:0] op_wdata [2];

    mbs_bus_responder #(.DEPTH(DEPTH), .WAIT_STATES(WS), .ERR_DATA(ERR_WORD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .we           (we),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .rdata        (rdata),
        .ack          (ack),
        .err          (err),
        .cpu_pause    (cpu_pause),
        .data_bus_out (data_bus_out),
        .addr_bus_out (addr_bus_out),
        .ctrl_bus_out (ctrl_bus_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return {32'b0, a} < 64'(DEPTH * 4);
    endfunction

    task automatic set_op(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
        op_we[k] = w;
        op_addr[k] = a;
        op_wdata[k] = d;
    endtask

    task automatic rand_op(input int k);
        int unsigned r, idx;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r == 0) a = 32'(DEPTH * 4) + 32'($urandom_range(0, 63));
        else if (r == 1) a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else begin
            idx = (r == 2) ? DEPTH - 1 : $urandom_range(0, 15);
            a = 32'(idx * 4) + 32'($urandom_range(0, 3));
        end
        idx = a[31:2];
        if (addr_ok(a) && !mem_model.exists(idx)) set_op(k, 1'b1, a, $urandom());
        else set_op(k, 1'($urandom_range(0, 1)), a, $urandom());
    endtask

    // Caller is positioned just after a rising edge; mask selects participating CPUs.
    task automatic run_txn(input logic [1:0] mask, input bit drop_early);
        int first, ncyc;
        int exp_cyc [2];
        logic [1:0] exp_ack;
        first = (mask == 2'b11) ? int'(!lg_model) : (mask[1] ? 1 : 0);
        exp_cyc[first] = LAT;
        exp_cyc[1 - first] = 2 * LAT + 1;
        ncyc = (mask == 2'b11) ? 2 * LAT + 3 : LAT + 2;
        addr0 = op_addr[0];  wdata0 = op_wdata[0];
        addr1 = op_addr[1];  wdata1 = op_wdata[1];
        we = {op_we[1], op_we[0]};
        req = mask;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            exp_ack = '0;
            for (int k = 0; k < 2; k++) begin
                if (mask[k] && exp_cyc[k] == c) exp_ack[k] = 1'b1;
            end
            check_val("ack", 32'(ack), 32'(exp_ack));
            check_val("cpu_pause", 32'(cpu_pause), 32'(req & ~exp_ack));
            for (int k = 0; k < 2; k++) begin
                if (exp_ack[k]) begin
                    if (addr_ok(op_addr[k])) begin
                        if (op_we[k]) mem_model[op_addr[k][31:2]] = op_wdata[k];
                        else rdata_model = mem_model[op_addr[k][31:2]];
                    end else if (!op_we[k]) begin
                        rdata_model = ERR_WORD;
                    end
                    check_val("rdata", rdata, rdata_model);
                    check_val("err", 32'(err), 32'(!addr_ok(op_addr[k])));
                    check_val("addr_bus", addr_bus_out, op_addr[k]);
                    check_val("data_bus", data_bus_out, op_we[k] ? op_wdata[k] : rdata_model);
                    check_val("ctrl_owner", 32'(ctrl_bus_out[5]), 32'(k));
                    lg_model = 1'(k);
                    req[k] = 1'b0;
                    $display("txn cpu%0d %s addr=%h data=%h err=%0b", k,
                             op_we[k] ? "WR" : "RD", op_addr[k],
                             op_we[k] ? op_wdata[k] : rdata, err);
                end
            end
            if (drop_early && c == 1) req = '0;
        end
        check_val("idle_after", 32'(ctrl_bus_out), 32'h0000_0000 | 32'(ctrl_bus_out[5:4] << 4));
    endtask

    initial begin
        #5 rst_n = 1'b0;
        #5 rst_n = 1'b1;
        #2;
        check_val("rst_rdata", rdata, 32'h0);
        check_val("rst_ack", 32'(ack), 32'h0);
        check_val("rst_err", 32'(err), 32'h0);
        check_val("rst_pause", 32'(cpu_pause), 32'h0);
        check_val("rst_data_bus", data_bus_out, 32'h0);
        check_val("rst_addr_bus", addr_bus_out, 32'h0);
        check_val("rst_ctrl_bus", ctrl_bus_out, 32'h0);
        @(posedge clk); #1;

        // Contention right after reset: grants 0,1,0,1.
        set_op(0, 1'b1, 32'h0000_0040, 32'hCAFE_0000);
        set_op(1, 1'b1, 32'h0000_0044, 32'hCAFE_0001);
        run_txn(2'b11, 1'b0);
        set_op(0, 1'b0, 32'h0000_0044, 32'h0);
        set_op(1, 1'b0, 32'h0000_0040, 32'h0);
        run_txn(2'b11, 1'b0);

        // cpu0 write then read back.
        set_op(0, 1'b1, 32'h0000_0010, 32'h1234_5678);
        run_txn(2'b01, 1'b0);
        set_op(0, 1'b0, 32'h0000_0010, 32'h0);
        run_txn(2'b01, 1'b0);
        check_val("rd_0x10", rdata, 32'h1234_5678);

        // Out-of-range access from cpu1 must leave word 0 intact.
        set_op(0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D);
        run_txn(2'b01, 1'b0);
        set_op(1, 1'b0, 32'(DEPTH * 4), 32'h0);
        run_txn(2'b10, 1'b0);
        check_val("oor_rdata", rdata, ERR_WORD);
        set_op(1, 1'b1, 32'(DEPTH * 4), 32'h1111_2222);
        run_txn(2'b10, 1'b0);
        set_op(1, 1'b0, 32'h0000_0000, 32'h0);
        run_txn(2'b10, 1'b0);
        check_val("mem0_kept", rdata, 32'h0BAD_F00D);

        // Request dropped mid-access still completes.
        set_op(0, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5);
        run_txn(2'b01, 1'b1);
        set_op(0, 1'b0, 32'h0000_0020, 32'h0);
        run_txn(2'b01, 1'b0);
        check_val("rd_0x20", rdata, 32'hA5A5_A5A5);

        // Reset while cpu1 read is in ACCESS.
        addr1 = 32'h0000_0010;  we = 2'b00;  req = 2'b10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("midrst_ack", 32'(ack), 32'h0);
        check_val("midrst_ctrl", ctrl_bus_out, 32'h0);
        req = '0;
        @(posedge clk); #1;
        check_val("midrst_ack_edge", 32'(ack), 32'h0);
        rst_n = 1'b1;
        lg_model = 1'b1;
        rdata_model = '0;
        @(posedge clk); #1;
        set_op(0, 1'b0, 32'h0000_0010, 32'h0);
        set_op(1, 1'b0, 32'h0000_0020, 32'h0);
        run_txn(2'b11, 1'b0);

        // Randomized traffic.
        for (int t = 0; t < 60; t++) begin
            int unsigned m;
            m = $urandom_range(1, 3);
            rand_op(0);
            rand_op(1);
            run_txn(2'(m), (m != 3) && ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
